paralelo_serial_tx: RTL

- Transmit-side parallel-to-serial stage that sits directly upstream of the serial-to-parallel transmit block.
- Accepts 8-bit bytes through a valid/ready handshake and serializes them at one bit per clock.
- After reset it sends a fixed number of COM symbols so the downstream stage can align and leave IDLE.
- Whenever no byte is offered, it fills the line with COM symbols.

---
 rtl/paralelo_serial_tx.sv | 66 ++++++
 1 files changed

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmit stage: COM preamble after reset, then one byte per 8 clocks.
// Define PARALELO_SERIAL_TX_LSB_FIRST_EN to shift bit0 out first instead of bit7.
module paralelo_serial_tx #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       active_out
);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_sym_cnt;
    logic       w_load;
    logic       w_accept;
    logic [7:0] w_shift;

    assign w_load     = (r_bit_cnt == 3'd7);
    assign ready_out  = (r_state == ACTIVE) && w_load;
    assign active_out = (r_state == ACTIVE);
    assign w_accept   = ready_out && valid_in;

`ifdef PARALELO_SERIAL_TX_LSB_FIRST_EN
    assign serial_out = r_shreg[0];
    assign w_shift    = {1'b0, r_shreg[7:1]};
`else
    assign serial_out = r_shreg[7];
    assign w_shift    = {r_shreg[6:0], 1'b0};
`endif

    always_comb begin
        w_state_nxt = r_state;
        // Leave SYNC on the load edge that inserts the last preamble COM
        if (r_state == SYNC && w_load && r_sym_cnt == 4'(SYNC_COUNT - 1))
            w_state_nxt = ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= SYNC;
            r_shreg   <= 8'h00;
            r_bit_cnt <= 3'd7;
            r_sym_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_load) begin
                r_shreg <= w_accept ? data_in : COM_SYMBOL;
                if (r_state == SYNC)
                    r_sym_cnt <= r_sym_cnt + 4'd1;
            end else begin
                r_shreg <= w_shift;
            end
        end
    end

endmodule
